// File: rtl/seq_detect_param_pkg.sv
// Shared constants for the programmable serial pattern detector.
package seq_det_pkg;

  // Legal range of the pattern window length.
  localparam int unsigned PAT_W_MIN = 2;
  localparam int unsigned PAT_W_MAX = 32;

  // Defaults matching the fixed 4-bit detectors this block replaces.
  localparam int unsigned DEF_PAT_W   = 4;
  localparam logic [3:0]  DEF_PATTERN = 4'b0101;
  localparam int unsigned DEF_CNT_W   = 8;

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating event counter with synchronous clear and a sticky saturation flag.
// The flag rises when an increment arrives while the count is already all-ones,
// i.e. once at least one event has been lost.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc) begin
      if (cnt == '1) begin
        sat <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Programmable serial pattern detector: compares a PAT_W-bit history window of
// the qualified serial input against a runtime-loadable pattern, with
// overlapping or non-overlapping detection and a saturating match count.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int unsigned       PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0]  PATTERN = PAT_W'(DEF_PATTERN),
  parameter int unsigned       CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             clr_cnt,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_detect_param: PAT_W must be in 2..32");
  end

  localparam int unsigned      FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist, hist_n, hist_shift;
  logic [FILL_W-1:0] fill, fill_n, fill_inc;
  logic [PAT_W-1:0]  pat;
  logic              hit;

  // Next window/fill and match decision; a load flushes the window and drops din.
  always_comb begin
    hist_shift = {hist[PAT_W-2:0], din};
    fill_inc   = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    hist_n     = hist;
    fill_n     = fill;
    hit        = 1'b0;
    if (pat_load) begin
      hist_n = '0;
      fill_n = '0;
    end else if (din_valid) begin
      hit    = (fill_inc == FILL_FULL) && (hist_shift == pat);
      hist_n = hist_shift;
      // Non-overlapping mode only needs the fill reset; the stale history
      // cannot match again until PAT_W fresh bits have replaced it.
      fill_n = (hit && !overlap) ? '0 : fill_inc;
    end
  end

  // Window, fill, pattern and registered match pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
      pat  <= PATTERN;
      y    <= 1'b0;
    end else begin
      hist <= hist_n;
      fill <= fill_n;
      if (pat_load) begin
        pat <= pat_in;
      end
      y <= hit;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .inc   (hit),
    .cnt   (match_cnt),
    .sat   (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: two instances (CNT_W=8 and CNT_W=2)
// share the same stimulus; a bit-list reference model predicts every cycle.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset, din, din_valid, overlap, pat_load, clr_cnt;
  logic [3:0] pat_in;
  logic       y8, sat8, y2, sat2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b0101), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .clr_cnt(clr_cnt),
    .y(y8), .match_cnt(cnt8), .cnt_sat(sat8)
  );

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b0101), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .clr_cnt(clr_cnt),
    .y(y2), .match_cnt(cnt2), .cnt_sat(sat2)
  );

  typedef struct {
    logic       y;
    logic [7:0] c8;
    logic       s8;
    logic [1:0] c2;
    logic       s2;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   hits_seen = 0;

  // Reference model: list of bits received since reset/load/flush.
  int   win[$];
  int   mpat;
  int   m_c8, m_c2;
  bit   m_s8, m_s2;

  task automatic model(input logic r, input logic dv, input logic d, input logic ov,
                       input logic pl, input logic [3:0] pi, input logic clr);
    exp_t e;
    bit   hit = 0;
    int   v;
    if (r) begin
      win.delete();
      mpat = 5;
      m_c8 = 0; m_s8 = 0; m_c2 = 0; m_s2 = 0;
    end else begin
      if (pl) begin
        mpat = int'(pi);
        win.delete();
      end else if (dv) begin
        win.push_back(int'(d));
        if (win.size() > 4) void'(win.pop_front());
        if (win.size() == 4) begin
          v = 0;
          foreach (win[i]) v = v * 2 + win[i];
          hit = (v == mpat);
          if (hit && !ov) win.delete();
        end
      end
      if (clr) begin
        m_c8 = 0; m_s8 = 0; m_c2 = 0; m_s2 = 0;
      end else if (hit) begin
        if (m_c8 == 255) m_s8 = 1; else m_c8++;
        if (m_c2 == 3)   m_s2 = 1; else m_c2++;
      end
    end
    e.y  = hit;
    e.c8 = 8'(m_c8);
    e.s8 = m_s8;
    e.c2 = 2'(m_c2);
    e.s2 = m_s2;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic dv, input logic d, input logic ov,
                      input logic pl, input logic [3:0] pi, input logic clr);
    reset = r; din_valid = dv; din = d; overlap = ov;
    pat_load = pl; pat_in = pi; clr_cnt = clr;
    model(r, dv, d, ov, pl, pi, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic d, input logic ov);
    step(1'b0, 1'b1, d, ov, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic gap();
    step(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'(i), 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w, input logic ov);
    for (int i = 31; i >= 0; i--) bit_in(w[i], ov);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("y8",   {7'd0, y8},   {7'd0, e.y});
      check("cnt8", cnt8,         e.c8);
      check("sat8", {7'd0, sat8}, {7'd0, e.s8});
      check("y2",   {7'd0, y2},   {7'd0, e.y});
      check("cnt2", {6'd0, cnt2}, {6'd0, e.c2});
      check("sat2", {7'd0, sat2}, {7'd0, e.s2});
      if (e.y) hits_seen++;
    end
  end

  initial begin
    int h0;
    int wait_cnt;
    reset = 1'b0; din = 1'b0; din_valid = 1'b0; overlap = 1'b0;
    pat_load = 1'b0; pat_in = '0; clr_cnt = 1'b0;

    // Reset with din toggling, then the default pattern through detection.
    do_reset(2);
    bit_in(0, 1); bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);

    // Overlapping and non-overlapping runs over the same word.
    do_reset(1);
    send_word(32'h255D255D, 1'b1);
    do_reset(1);
    send_word(32'h255D255D, 1'b0);

    // Gapped bits, load colliding with a valid bit, then the new pattern.
    do_reset(1);
    bit_in(0, 1); gap(); gap(); bit_in(1, 1); gap(); bit_in(0, 1); gap(); bit_in(1, 1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1100, 1'b0);
    bit_in(1, 1); bit_in(1, 1); bit_in(0, 1); gap(); bit_in(0, 1);

    // Saturation: 5 overlapping hits, then a clear colliding with a hit.
    do_reset(1);
    bit_in(0, 1); bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);
    for (int i = 0; i < 4; i++) begin bit_in(0, 1); bit_in(1, 1); end
    bit_in(0, 1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);

    // Mid-stream reset discards the partial match.
    bit_in(0, 1); bit_in(1, 1); bit_in(0, 1);
    do_reset(1);
    bit_in(1, 1);
    bit_in(0, 1); bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);

    // Randomised traffic.
    h0 = hits_seen;
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      r = $urandom_range(0, 199);
      step(r == 0,
           $urandom_range(0, 3) != 0,
           1'($urandom),
           (i / 97) % 2 == 0,
           r >= 1 && r <= 4,
           4'($urandom),
           r >= 5 && r <= 7);
    end

    // Drain the scoreboard with a bounded wait.
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    checks++;
    if (hits_seen <= h0) begin
      errors++;
      $display("FAIL random_hits: got %0d hits in random phase, expected more than 0", hits_seen - h0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
